// File: rtl/qam_deframer.sv
// qam_deframer: hunts for SYNC_WORD in a QAM-16 nibble stream, reads an 8-bit
// length, packs payload nibbles into bytes and forwards them through a small
// FIFO to an AXI-Stream byte port (tlast on the final payload byte).
// Optional macro QAM_DEFRAME_CHK_EN adds a trailing XOR checksum byte (CHK state).
module qam_deframer #(
  parameter logic [15:0] SYNC_WORD  = 16'hEB90,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic       axi_clk,
  input  logic       axi_rstn,
  input  logic       din_valid,
  input  logic [3:0] din,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       sync_locked,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

`ifdef QAM_DEFRAME_CHK_EN
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAY, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAY} state_t;
`endif

  state_t      r_state, w_nxt;
  logic [15:0] r_sr;
  logic        r_ph;          // 0: expecting high nibble, 1: low nibble
  logic [3:0]  r_hi;
  logic [7:0]  r_cnt;
  logic        r_pend;        // byte assembled last cycle, written to FIFO this cycle
  logic [7:0]  r_pend_data;
  logic        r_pend_last;
  logic        r_locked, r_err, r_ovf;
  logic [7:0]  r_xor;
  logic [8:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;

  logic [15:0] w_sr_nxt;
  logic [7:0]  w_byte;
  logic [AW:0] w_count;
  logic        w_empty, w_full, w_pop, w_push, w_drop, w_abort;
  logic        w_len0, w_bad_chk;
  logic [8:0]  w_head;

  assign w_sr_nxt = {r_sr[11:0], din};
  assign w_byte   = {r_hi, din};
  assign w_count  = r_wp - r_rp;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == DEPTH_L);
  assign w_pop    = m_axis_tvalid && m_axis_tready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push   = r_pend && (!w_full || w_pop);
  assign w_drop   = r_pend && w_full && !w_pop;
  assign w_abort  = w_drop && (r_state != S_HUNT);
  assign w_head   = r_mem[r_rp[AW-1:0]];

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? 8'h00 : w_head[7:0];
  assign m_axis_tlast  = w_empty ? 1'b0  : w_head[8];
  assign sync_locked   = r_locked;
  assign frame_err     = r_err;
  assign overflow      = r_ovf;

  // Next-state decode; a dropped byte abandons the frame from any locked state.
  always_comb begin
    w_nxt     = r_state;
    w_len0    = 1'b0;
    w_bad_chk = 1'b0;
    if (din_valid) begin
      case (r_state)
        S_HUNT: if (w_sr_nxt == SYNC_WORD) w_nxt = S_LEN;
        S_LEN: if (r_ph) begin
          if (w_byte == 8'h00) begin
            w_nxt  = S_HUNT;
            w_len0 = 1'b1;
          end else begin
            w_nxt = S_PAY;
          end
        end
`ifdef QAM_DEFRAME_CHK_EN
        S_PAY: if (r_ph && r_cnt == 8'd1) w_nxt = S_CHK;
        S_CHK: if (r_ph) begin
          w_nxt     = S_HUNT;
          w_bad_chk = (w_byte != r_xor);
        end
`else
        S_PAY: if (r_ph && r_cnt == 8'd1) w_nxt = S_HUNT;
`endif
        default: w_nxt = S_HUNT;
      endcase
    end
    if (w_abort) w_nxt = S_HUNT;
  end

  // Frame state, nibble assembly, byte counter, checksum and status pulses.
  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_state     <= S_HUNT;
      r_sr        <= '0;
      r_ph        <= 1'b0;
      r_hi        <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_pend_last <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_xor       <= '0;
    end else begin
      r_state  <= w_nxt;
      r_locked <= (w_nxt != S_HUNT);
      r_err    <= (w_len0 || w_bad_chk) && !w_abort;
      r_ovf    <= w_drop;
      r_pend   <= 1'b0;
      if (w_abort) begin
        r_sr <= '0;
        r_ph <= 1'b0;
      end else if (din_valid) begin
        if (r_state == S_HUNT) begin
          r_sr <= (w_nxt == S_LEN) ? 16'h0000 : w_sr_nxt;
          r_ph <= 1'b0;
        end else begin
          r_ph <= ~r_ph;
          if (!r_ph) r_hi <= din;
        end
        if (r_state == S_LEN && r_ph) begin
          r_cnt <= w_byte;
          r_xor <= '0;
        end
        if (r_state == S_PAY && r_ph) begin
          r_pend      <= 1'b1;
          r_pend_data <= w_byte;
          r_pend_last <= (r_cnt == 8'd1);
          r_cnt       <= r_cnt - 8'd1;
          r_xor       <= r_xor ^ w_byte;
        end
      end
    end
  end

  // FIFO pointers; reset empties the FIFO.
  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
    end
  end

  // FIFO storage of {tlast, data}; contents are only visible while non-empty.
  always_ff @(posedge axi_clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {r_pend_last, r_pend_data};
  end

endmodule

// File: tb/tb_qam_deframer.sv
// tb_qam_deframer: directed + randomized checks of qam_deframer against a
// frame-level model (expected byte queue built from the frames sent).
module tb_qam_deframer;
  logic       axi_clk = 1'b0;
  logic       axi_rstn = 1'b0;
  logic       din_valid = 1'b0;
  logic [3:0] din = 4'h0;
  logic       m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, sync_locked, frame_err, overflow;

  qam_deframer dut (
    .axi_clk(axi_clk), .axi_rstn(axi_rstn), .din_valid(din_valid), .din(din),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .sync_locked(sync_locked), .frame_err(frame_err), .overflow(overflow));

  always #5 axi_clk = ~axi_clk;

  int n_cmp = 0, n_bad = 0;
  logic [8:0] obs_q[$], exp_q[$];
  logic [7:0] pl_q[$];
  int err_hi, err_rise, ovf_hi, ovf_rise, stall_bad, cyc, rmode;
  logic rfix, p_err, p_ovf, stall_pend, lock_at_ovf;
  logic [8:0] p_out;
  logic tr_v[256], tr_l[256], tr_lock[256];
  logic [7:0] tr_d[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs (state after previous edge), pick tready, drive din.
  task automatic tick(input logic v, input logic [3:0] n);
    @(negedge axi_clk);
    if (stall_pend && !(m_axis_tvalid === 1'b1 && {m_axis_tlast, m_axis_tdata} === p_out))
      stall_bad++;
    if (frame_err === 1'b1) begin err_hi++; if (!p_err) err_rise++; end
    if (overflow === 1'b1) begin
      ovf_hi++; if (!p_ovf) ovf_rise++;
      lock_at_ovf = sync_locked;
    end
    p_err = (frame_err === 1'b1);
    p_ovf = (overflow === 1'b1);
    if (cyc < 256) begin
      tr_v[cyc] = m_axis_tvalid; tr_d[cyc] = m_axis_tdata;
      tr_l[cyc] = m_axis_tlast;  tr_lock[cyc] = sync_locked;
    end
    cyc++;
    case (rmode)
      0:       m_axis_tready = rfix;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
    if (m_axis_tvalid === 1'b1 && m_axis_tready) obs_q.push_back({m_axis_tlast, m_axis_tdata});
    stall_pend = (m_axis_tvalid === 1'b1) && !m_axis_tready;
    p_out = {m_axis_tlast, m_axis_tdata};
    din_valid = v;
    din = n;
  endtask

  task automatic clr();
    obs_q.delete(); exp_q.delete();
    err_hi = 0; err_rise = 0; ovf_hi = 0; ovf_rise = 0; stall_bad = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    stall_pend = 1'b0;
    tick(1'b0, 4'h0);
    axi_rstn = 1'b0;
    tick(1'b0, 4'h0);
    tick(1'b0, 4'h0);
    axi_rstn = 1'b1;
    stall_pend = 1'b0;
    clr();
  endtask

  // gap: percent chance of an idle cycle before each nibble (bounded).
  task automatic nib(input logic [3:0] n, input int gap);
    for (int k = 0; k < 4 && $urandom_range(0, 99) < gap; k++)
      tick(1'b0, 4'($urandom_range(0, 15)));
    tick(1'b1, n);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    nib(b[7:4], gap);
    nib(b[3:0], gap);
  endtask

  task automatic send_sync(input int gap);
    logic [15:0] sw;
    sw = 16'hEB90;
    for (int i = 3; i >= 0; i--) nib(sw[i*4 +: 4], gap);
  endtask

  // Sends sync, length, pl_q (and the XOR check when enabled); the first nexp
  // payload bytes are expected at the output, tlast only on the true last byte.
  task automatic send_frame(input int gap, input int nexp);
    logic [7:0] x;
    x = 8'h00;
    send_sync(gap);
    send_byte(8'(pl_q.size()), gap);
    foreach (pl_q[i]) begin
      send_byte(pl_q[i], gap);
      x = x ^ pl_q[i];
      if (i < nexp) exp_q.push_back({(i == pl_q.size() - 1), pl_q[i]});
    end
`ifdef QAM_DEFRAME_CHK_EN
    send_byte(x, gap);
`endif
  endtask

  task automatic cmp_q(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic drain();
    rmode = 0; rfix = 1'b1;
    idle(40);
  endtask

  initial begin
    int lo0, lo1, last_idx;
    rmode = 0; rfix = 1'b0; cyc = 0;
    p_err = 1'b0; p_ovf = 1'b0; stall_pend = 1'b0; lock_at_ovf = 1'b1;
    clr();

    // Reset values
    axi_rstn = 1'b0;
    tick(1'b0, 4'h0); tick(1'b1, 4'hE); tick(1'b0, 4'h0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_locked", sync_locked, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    axi_rstn = 1'b1;
    clr();

    // Basic frame 0x12,0x34 at full rate: latency and lock window
    rfix = 1'b1;
    pl_q = '{8'h12, 8'h34};
    cyc = 0;
    send_frame(0, 2);
    idle(6);
    lo0 = 7; lo1 = 9;
`ifdef QAM_DEFRAME_CHK_EN
    last_idx = 11;
`else
    last_idx = 9;
`endif
    chk("t1_v_early", tr_v[lo0+1], 0);
    chk("t1_v0", tr_v[lo0+2], 1);
    chk("t1_d0", tr_d[lo0+2], 8'h12);
    chk("t1_l0", tr_l[lo0+2], 0);
    chk("t1_v_gap", tr_v[lo1+1], 0);
    chk("t1_v1", tr_v[lo1+2], 1);
    chk("t1_d1", tr_d[lo1+2], 8'h34);
    chk("t1_l1", tr_l[lo1+2], 1);
    chk("t1_lock_pre", tr_lock[3], 0);
    chk("t1_lock_rise", tr_lock[4], 1);
    chk("t1_lock_hold", tr_lock[last_idx], 1);
    chk("t1_lock_fall", tr_lock[last_idx+1], 0);
    cmp_q("t1_out");
    chk("t1_err", err_hi, 0);

    // Overlapping sync after noise 3,E
    nib(4'h3, 0); nib(4'hE, 0);
    pl_q = '{8'hA5};
    send_frame(0, 1);
    drain();
    cmp_q("t2_out");
    chk("t2_err", err_hi, 0);

    // Zero length: one-cycle frame_err, back in HUNT, nothing written
    clr();
    send_sync(0); send_byte(8'h00, 0);
    idle(4);
    chk("t3_err_hi", err_hi, 1);
    chk("t3_err_rise", err_rise, 1);
    chk("t3_tvalid", m_axis_tvalid, 0);
    chk("t3_locked", sync_locked, 0);
    chk("t3_nowrite", obs_q.size(), 0);
    pl_q = '{8'h77};
    send_frame(0, 1);
    drain();
    cmp_q("t3_after");

    // Overflow: 32 bytes into a stalled 16-deep FIFO
    clr();
    rfix = 1'b0;
    pl_q.delete();
    for (int i = 0; i < 32; i++) pl_q.push_back(8'(i));
    send_frame(0, 16);
    idle(3);
    chk("t4_ovf_hi", ovf_hi, 1);
    chk("t4_ovf_rise", ovf_rise, 1);
    chk("t4_lock_at_ovf", lock_at_ovf, 0);
    chk("t4_tvalid_held", m_axis_tvalid, 1);
    chk("t4_head", m_axis_tdata, 8'h00);
    drain();
    cmp_q("t4_drain");
    pl_q = '{8'h5A};
    send_frame(0, 1);
    drain();
    cmp_q("t4_next");

    // tready toggling every cycle during a 4-byte frame
    clr();
    rmode = 1;
    pl_q.delete();
    for (int i = 0; i < 4; i++) pl_q.push_back(8'($urandom_range(0, 255)));
    send_frame(0, 4);
    idle(12);
    chk("t5_stable", stall_bad, 0);
    drain();
    cmp_q("t5_out");

    // Reset mid-frame discards FIFO contents and the partial frame
    rfix = 1'b0;
    send_sync(0); send_byte(8'h08, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    idle(3);
    chk("t6_buffered", m_axis_tvalid, 1);
    do_reset();
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_tdata", m_axis_tdata, 0);
    chk("t6_rst_locked", sync_locked, 0);
    rfix = 1'b1;
    pl_q = '{8'hC3};
    send_frame(0, 1);
    drain();
    cmp_q("t6_after");

    // Randomized frames with gaps, noise and random backpressure
    clr();
    rmode = 2;
    for (int f = 0; f < 20; f++) begin
      int len, nn;
      nn = $urandom_range(0, 3);
      for (int k = 0; k < nn; k++) nib(4'($urandom_range(0, 13)), 30);
      len = $urandom_range(1, 10);
      pl_q.delete();
      for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom_range(0, 255)));
      send_frame(40, len);
    end
    idle(10);
    chk("t7_stable", stall_bad, 0);
    drain();
    cmp_q("t7_out");
    chk("t7_err", err_hi, 0);
    chk("t7_ovf", ovf_hi, 0);

`ifdef QAM_DEFRAME_CHK_EN
    // Checksum: good check silent, bad check pulses frame_err
    clr();
    send_sync(0); send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h26, 0);
    exp_q.push_back({1'b0, 8'h12}); exp_q.push_back({1'b1, 8'h34});
    idle(4);
    chk("t8_good_err", err_hi, 0);
    send_sync(0); send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h27, 0);
    exp_q.push_back({1'b0, 8'h12}); exp_q.push_back({1'b1, 8'h34});
    idle(4);
    chk("t8_bad_err_hi", err_hi, 1);
    chk("t8_bad_err_rise", err_rise, 1);
    chk("t8_locked", sync_locked, 0);
    drain();
    cmp_q("t8_out");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
